// File: rtl/perceptron_predictor_param_if.sv
// Fetch-side bundle for the perceptron direction predictor: predict request and
// response, resolve-time training/recovery request, and table-clear status.
// master = pipeline (drives req/upd), slave = predictor.
interface perceptron_predictor_param_if #(
  parameter int PC_W     = 32,
  parameter int HIST_LEN = 16,
  parameter int WEIGHT_W = 8
);
  localparam int SUM_W = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;

  logic                       req_valid;
  logic [PC_W-1:0]            req_pc;
  logic                       req_ready;
  logic                       pred_valid;
  logic                       pred_taken;
  logic signed [SUM_W-1:0]    pred_sum;
  logic [HIST_LEN-1:0]        pred_ghr;
  logic                       upd_valid;
  logic [PC_W-1:0]            upd_pc;
  logic [HIST_LEN-1:0]        upd_ghr;
  logic signed [SUM_W-1:0]    upd_sum;
  logic                       upd_taken;
  logic                       upd_mispredict;
  logic                       init_done;

  modport master (
    output req_valid, req_pc, upd_valid, upd_pc, upd_ghr, upd_sum, upd_taken, upd_mispredict,
    input  req_ready, pred_valid, pred_taken, pred_sum, pred_ghr, init_done
  );

  modport slave (
    input  req_valid, req_pc, upd_valid, upd_pc, upd_ghr, upd_sum, upd_taken, upd_mispredict,
    output req_ready, pred_valid, pred_taken, pred_sum, pred_ghr, init_done
  );
endinterface

// File: rtl/perceptron_predictor_param.sv
// Hashed perceptron direction predictor with threshold training and GHR recovery.
// Latency: prediction registered 1 cycle after accept; training/recovery land on the upd_valid edge.
// Backpressure: req_ready low during table clear and in a recovery cycle; otherwise 1 req/cycle.
// Optional: define PERCEPTRON_STATS_EN to add stat_pred/stat_mispred saturating counters.
module perceptron_predictor_param #(
  parameter int PC_W        = 32,
  parameter int HIST_LEN    = 16,
  parameter int TABLE_DEPTH = 64,
  parameter int WEIGHT_W    = 8,
  parameter int THETA       = 44
) (
  input  logic clk,
  input  logic rst_n,
  perceptron_predictor_param_if.slave bus
`ifdef PERCEPTRON_STATS_EN
  ,
  output logic [31:0] stat_pred,
  output logic [31:0] stat_mispred
`endif
);

  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam int SUM_W = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;
  // Row layout: slot 0 is the bias, slot i+1 is the weight for history bit i.
  localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;
  localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   clear_cnt, clear_cnt_nxt;
  logic [HIST_LEN-1:0] spec_ghr;
  logic [ROW_W-1:0]   wt_mem [TABLE_DEPTH];

  logic               run;
  logic               req_rdy;
  logic               accept;
  logic               upd_fire;
  logic               recover;
  logic               train_en;
  logic [IDX_W-1:0]   prd_idx;
  logic [IDX_W-1:0]   upd_idx;
  logic [ROW_W-1:0]   prd_row;
  logic [ROW_W-1:0]   upd_row;
  logic [ROW_W-1:0]   upd_row_new;
  logic signed [SUM_W-1:0] prd_sum;
  logic               prd_taken;
  logic               upd_neg;
  logic               upd_wrong;
  logic [SUM_W:0]     upd_ext;
  logic [SUM_W:0]     upd_mag;
  logic               upd_weak;
  logic               unused_pc_bits;

  function automatic logic [SUM_W-1:0] sext(input logic [WEIGHT_W-1:0] w);
    return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  // One saturating +/-1 step; the extremes stick instead of wrapping.
  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w, input logic inc);
    logic [WEIGHT_W-1:0] r;
    r = w;
    if (inc) begin
      if (w != W_MAX) r = w + WEIGHT_W'(1);
    end else begin
      if (w != W_MIN) r = w - WEIGHT_W'(1);
    end
    return r;
  endfunction

  // Only the hashed PC bits feed the index; the rest are intentionally dropped.
  assign unused_pc_bits = ^{bus.req_pc, bus.upd_pc};

  assign run      = (state == ST_RUN);
  assign req_rdy  = run & ~(bus.upd_valid & bus.upd_mispredict);
  assign accept   = bus.req_valid & req_rdy;
  assign upd_fire = run & bus.upd_valid;
  assign recover  = upd_fire & bus.upd_mispredict;

  assign prd_idx = bus.req_pc[IDX_W+1:2] ^ spec_ghr[IDX_W-1:0];
  assign upd_idx = bus.upd_pc[IDX_W+1:2] ^ bus.upd_ghr[IDX_W-1:0];
  assign prd_row = wt_mem[prd_idx];
  assign upd_row = wt_mem[upd_idx];

  assign bus.req_ready = req_rdy;
  assign bus.init_done = run;

  // Clear FSM: walk every row once, then hand over to normal operation.
  always_comb begin
    state_nxt     = state;
    clear_cnt_nxt = clear_cnt;
    case (state)
      ST_INIT: begin
        clear_cnt_nxt = clear_cnt + IDX_W'(1);
        if (clear_cnt == IDX_W'(TABLE_DEPTH - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt     = ST_INIT;
        clear_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state and clear pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clear_cnt <= '0;
    end else begin
      state     <= state_nxt;
      clear_cnt <= clear_cnt_nxt;
    end
  end

  // Dot product of the indexed row against the speculative history (bit set = +w).
  always_comb begin
    prd_sum = sext(prd_row[WEIGHT_W-1:0]);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (spec_ghr[i]) prd_sum = prd_sum + sext(prd_row[(i+1)*WEIGHT_W +: WEIGHT_W]);
      else             prd_sum = prd_sum - sext(prd_row[(i+1)*WEIGHT_W +: WEIGHT_W]);
    end
    prd_taken = ~prd_sum[SUM_W-1];
  end

  // Train when the returned sum picked the wrong direction or was not confident enough.
  always_comb begin
    upd_neg   = bus.upd_sum[SUM_W-1];
    upd_wrong = (~upd_neg) != bus.upd_taken;
    upd_ext   = {bus.upd_sum[SUM_W-1], bus.upd_sum};
    upd_mag   = upd_neg ? (~upd_ext + (SUM_W+1)'(1)) : upd_ext;
    upd_weak  = (upd_mag <= (SUM_W+1)'(THETA));
    train_en  = upd_fire & (upd_wrong | upd_weak);
  end

  // Next contents of the training row: bias follows outcome, weights follow agreement.
  always_comb begin
    upd_row_new = upd_row;
    upd_row_new[WEIGHT_W-1:0] = sat_step(upd_row[WEIGHT_W-1:0], bus.upd_taken);
    for (int i = 0; i < HIST_LEN; i++) begin
      upd_row_new[(i+1)*WEIGHT_W +: WEIGHT_W] =
        sat_step(upd_row[(i+1)*WEIGHT_W +: WEIGHT_W], bus.upd_ghr[i] == bus.upd_taken);
    end
  end

  // Weight table: cleared row by row during INIT, one training write per cycle in RUN.
  // Reads are combinational from the pre-edge state, so a same-row predict sees old weights.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      wt_mem[clear_cnt] <= '0;
    end else if (train_en) begin
      wt_mem[upd_idx] <= upd_row_new;
    end
  end

  // Speculative history: recovery from the resolved branch beats the predict shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_ghr <= '0;
    end else if (recover) begin
      spec_ghr <= {bus.upd_ghr[HIST_LEN-2:0], bus.upd_taken};
    end else if (accept) begin
      spec_ghr <= {spec_ghr[HIST_LEN-2:0], prd_taken};
    end
  end

  // Registered prediction response; valid pulses once per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_sum   <= '0;
      bus.pred_ghr   <= '0;
    end else begin
      bus.pred_valid <= accept;
      if (accept) begin
        bus.pred_taken <= prd_taken;
        bus.pred_sum   <= prd_sum;
        bus.pred_ghr   <= spec_ghr;
      end
    end
  end

`ifdef PERCEPTRON_STATS_EN
  // Saturating event counters for accepted predictions and resolved mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred    <= '0;
      stat_mispred <= '0;
    end else begin
      if (accept && (stat_pred != 32'hFFFF_FFFF))     stat_pred    <= stat_pred + 32'd1;
      if (recover && (stat_mispred != 32'hFFFF_FFFF)) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_perceptron_predictor_param.sv
// Directed bench for perceptron_predictor_param: clear timing, predict, train,
// saturation, recovery, same-row collision, reset restart (and counters when enabled).
module tb_perceptron_predictor_param;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

`ifdef PERCEPTRON_STATS_EN
  logic [31:0] stat_pred;
  logic [31:0] stat_mispred;
`endif

  perceptron_predictor_param_if #(.PC_W(32), .HIST_LEN(16), .WEIGHT_W(8)) bus ();

  perceptron_predictor_param #(
    .PC_W(32), .HIST_LEN(16), .TABLE_DEPTH(64), .WEIGHT_W(8), .THETA(44)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PERCEPTRON_STATS_EN
    ,
    .stat_pred    (stat_pred),
    .stat_mispred (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid      = 1'b0;
    bus.req_pc         = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_ghr        = '0;
    bus.upd_sum        = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [15:0] ghr, input int sum,
                        input logic taken, input logic misp);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_ghr        = ghr;
    bus.upd_sum        = 14'(sum);
    bus.upd_taken      = taken;
    bus.upd_mispredict = misp;
    tick();
    idle();
  endtask

  task automatic do_pred(input logic [31:0] pc);
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    tick();
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_init_done", bus.init_done, 0);
    check("rst_pred_valid", bus.pred_valid, 0);

    // Table clear takes exactly 64 cycles.
    rst_n = 1'b1;
    repeat (63) tick();
    check("init_63_done", bus.init_done, 0);
    check("init_63_ready", bus.req_ready, 0);
    tick();
    check("init_64_done", bus.init_done, 1);
    check("init_64_ready", bus.req_ready, 1);

    // First prediction from a cleared table.
    do_pred(32'h100);
    check("p0_valid", bus.pred_valid, 1);
    check("p0_sum", bus.pred_sum, 0);
    check("p0_taken", bus.pred_taken, 1);
    check("p0_ghr", bus.pred_ghr, 0);
    tick();
    check("p0_valid_drop", bus.pred_valid, 0);

    // Restore spec_ghr to 0 with a confident, correct update (no training).
    do_upd(32'h100, 16'h0000, -100, 1'b0, 1'b1);
    // Three mistrained-direction updates on row 0.
    repeat (3) do_upd(32'h100, 16'h0000, 0, 1'b0, 1'b0);
    do_pred(32'h100);
    check("train_sum", bus.pred_sum, -51);
    check("train_taken", bus.pred_taken, 0);
    check("train_ghr", bus.pred_ghr, 0);

    // Saturation on row 47 (pc 0x40 hashed with all-ones history).
    repeat (200) do_upd(32'h40, 16'hFFFF, 0, 1'b1, 1'b0);
    do_upd(32'h40, 16'hFFFF, 100, 1'b1, 1'b0);
    do_upd(32'h40, 16'hFFFF, 100, 1'b1, 1'b1);
    do_pred(32'h40);
    check("sat_sum", bus.pred_sum, 2159);
    check("sat_taken", bus.pred_taken, 1);
    check("sat_ghr", bus.pred_ghr, 16'hFFFF);

    // Recovery blocks a same-cycle request and rewrites the history.
    bus.req_valid      = 1'b1;
    bus.req_pc         = 32'h300;
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = 32'h200;
    bus.upd_ghr        = 16'h00F0;
    bus.upd_sum        = -14'sd100;
    bus.upd_taken      = 1'b1;
    bus.upd_mispredict = 1'b1;
    #1;
    check("rec_req_ready", bus.req_ready, 0);
    tick();
    idle();
    check("rec_no_pred", bus.pred_valid, 0);
    do_pred(32'h300);
    check("rec_ghr", bus.pred_ghr, 16'h01E1);

    // Same-row predict and train in one cycle: old weights predicted, new ones after.
    do_upd(32'h100, 16'h0000, -100, 1'b0, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h100;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h100;
    bus.upd_ghr   = 16'h0000;
    bus.upd_sum   = '0;
    bus.upd_taken = 1'b0;
    bus.upd_mispredict = 1'b0;
    tick();
    idle();
    check("coll_valid", bus.pred_valid, 1);
    check("coll_old_sum", bus.pred_sum, -51);
    do_pred(32'h100);
    check("coll_new_sum", bus.pred_sum, -68);

    // Reset mid-run restarts the clear and wipes the table.
    rst_n = 1'b0;
    #2;
    check("mrst_init_done", bus.init_done, 0);
    check("mrst_req_ready", bus.req_ready, 0);
    check("mrst_pred_valid", bus.pred_valid, 0);
`ifdef PERCEPTRON_STATS_EN
    check("mrst_stat_pred", stat_pred, 0);
    check("mrst_stat_mispred", stat_mispred, 0);
`endif
    tick();
    rst_n = 1'b1;
    repeat (63) tick();
    check("mrst_63_done", bus.init_done, 0);
    tick();
    check("mrst_64_done", bus.init_done, 1);
    do_pred(32'h100);
    check("mrst_sum", bus.pred_sum, 0);

`ifdef PERCEPTRON_STATS_EN
    repeat (9) do_pred(32'h100);
    repeat (3) do_upd(32'h100, 16'h0000, -100, 1'b0, 1'b1);
    check("stat_pred_10", stat_pred, 10);
    check("stat_mispred_3", stat_mispred, 3);
    rst_n = 1'b0;
    #2;
    check("stat_pred_clr", stat_pred, 0);
    check("stat_mispred_clr", stat_mispred, 0);
    check("stat_init_restart", bus.init_done, 0);
    tick();
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
